sync_gen: RTL and testbench
===========================

SYNC_GEN -- requirements
Module: sync_gen

Interface
REQ-001 Parameter DIV_NBIT, default 16: width of the sample-clock divider.
REQ-002 Parameter CNT_NBIT, default 9: width of the in-frame sample counter.
REQ-003 Parameter NCHN, default 4: number of simulated data channels; power of two, 1..16.
REQ-004 mclk  in  1  system clock; every register is clocked on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 en  in  1  run enable; low forces IDLE.
REQ-007 div_max  in  DIV_NBIT  sample period minus 1, in mclk cycles; values 0 are treated as 1.
REQ-008 frame_max  in  CNT_NBIT  samples per frame minus 1.
REQ-009 sync_len  in  CNT_NBIT  number of samples per frame with sync high; 0 means sync is never high.
REQ-010 mode  in  2  data pattern: 00 square, 01 walking-one, 10 PRBS-7, 11 all-low.
REQ-011 spclk  out  1  simulated sample clock.
REQ-012 sync  out  1  simulated frame sync.
REQ-013 data  out  NCHN  simulated channel data.
REQ-014 frame_tick  out  1  one-cycle pulse at each frame start.
REQ-015 sample_idx  out  CNT_NBIT  current sample index within the frame.

Function
REQ-016 FSM states are IDLE and RUN; IDLE->RUN on en=1; RUN->IDLE on the cycle after en=0, regardless of position in the frame.
REQ-017 On IDLE->RUN and at every frame wrap, div_max, frame_max, sync_len and mode are latched into shadow registers; mid-frame input changes have no effect until the next frame.
REQ-018 In RUN, div_cnt counts 0..div_max_s; at div_max_s it returns to 0 and the sample counter advances; the sample counter wraps from frame_max_s to 0.
REQ-019 All outputs are registered and follow the internal counters with exactly one mclk of latency.
REQ-020 spclk = 1 while div_cnt < (div_max_s+1)>>1, else 0 (50% duty for even periods; the high phase is one cycle shorter for odd periods).
REQ-021 sync = 1 while sample counter < sync_len_s; when sync_len_s > frame_max_s, sync stays high for the whole frame.
REQ-022 Square mode: all data bits = 1 while sample counter < (frame_max_s+1)>>1, else 0.
REQ-023 Walking mode: data[k] = 1 only when (sample counter mod NCHN) == k.
REQ-024 PRBS mode: 7-bit LFSR, polynomial x^7+x^6+1, seeded to 7'h7F at each frame start, advanced once per sample; data[k] = lfsr[k mod 7].
REQ-025 All-low mode: data = 0.
REQ-026 frame_tick is high for exactly one mclk, in the cycle when sample_idx first shows 0 in a frame, including the first frame after enable.
REQ-027 sample_idx outputs the registered sample counter.
REQ-028 Counters wrap modulo their width and never hold a value above the shadow limits; frame_max=0 gives one-sample frames with frame_tick once per sample period.

Reset
REQ-029 When rst_n=0: state IDLE; counters, shadows and LFSR cleared (LFSR to 7'h7F); spclk, sync, data, frame_tick and sample_idx all 0.
REQ-030 In IDLE, outputs are held at their reset values; re-enable always starts at div_cnt=0 with sample 0.

Verification
REQ-031 div_max=9, frame_max=511, sync_len=9, mode=00, en=1 -> spclk is 5 high / 5 low; sync is high for samples 0..8; data is high for samples 0..255; frame_tick every 5120 mclk.
REQ-032 mode=01, NCHN=4, div_max=3 -> data cycles 0001, 0010, 0100, 1000 at 4-mclk steps and wraps.
REQ-033 mode=10, frame_max=126 -> lfsr[0] sequence repeats identically every frame starting from seed 7F; period is 127.
REQ-034 Change frame_max from 511 to 15 mid-frame -> the current frame completes at 512 samples; the next frame is 16 samples.
REQ-035 Drop en at sample 100, then re-raise it -> all outputs are 0 within 2 mclk; on restart, frame_tick appears 1 mclk after entering RUN with sample_idx=0.
REQ-036 Assert rst_n low asynchronously mid-sample -> all outputs are 0 before the next mclk edge; div_max=0 behaves identically to div_max=1.

Source files
------------

// File: rtl/sync_gen.sv
// sync_gen: simulated sample-clock / frame-sync / channel-data generator.
//
// A sample divider (div_cnt) and an in-frame sample counter (smp_cnt) run
// while enabled; all outputs are registered copies of functions of those
// counters, so they lag the counters by exactly one mclk.
//
// Ports:
//   mclk        in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   en          in   run enable; low returns to IDLE
//   div_max     in   sample period minus 1 (0 is treated as 1)
//   frame_max   in   samples per frame minus 1
//   sync_len    in   samples per frame with sync high (0 = never)
//   mode        in   00 square, 01 walking-one, 10 PRBS-7, 11 all-low
//   spclk       out  simulated sample clock
//   sync        out  simulated frame sync
//   data        out  simulated channel data, NCHN bits
//   frame_tick  out  one-cycle pulse when sample_idx first shows 0 in a frame
//   sample_idx  out  registered sample counter
module sync_gen #(
    parameter int unsigned DIV_NBIT = 16,
    parameter int unsigned CNT_NBIT = 9,
    parameter int unsigned NCHN     = 4
) (
    input  logic                mclk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [DIV_NBIT-1:0] div_max,
    input  logic [CNT_NBIT-1:0] frame_max,
    input  logic [CNT_NBIT-1:0] sync_len,
    input  logic [1:0]          mode,
    output logic                spclk,
    output logic                sync,
    output logic [NCHN-1:0]     data,
    output logic                frame_tick,
    output logic [CNT_NBIT-1:0] sample_idx
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t state, state_nxt;

    logic [DIV_NBIT-1:0] div_max_s;
    logic [CNT_NBIT-1:0] frame_max_s;
    logic [CNT_NBIT-1:0] sync_len_s;
    logic [1:0]          mode_s;

    logic [DIV_NBIT-1:0] div_cnt;
    logic [CNT_NBIT-1:0] smp_cnt;
    logic [6:0]          lfsr;

    logic [DIV_NBIT-1:0] div_max_eff;
    logic                div_wrap;
    logic                smp_wrap;
    logic                load;
    logic [6:0]          lfsr_nxt;

    logic [DIV_NBIT:0]   half_period;
    logic [CNT_NBIT:0]   half_frame;
    logic [15:0]         lfsr_rep;
    logic                spclk_d;
    logic                sync_d;
    logic [NCHN-1:0]     data_d;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (en)  state_nxt = RUN;
            RUN:     if (!en) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------ control terms
    assign div_max_eff = (div_max == '0) ? DIV_NBIT'(1) : div_max;
    assign div_wrap    = (div_cnt == div_max_s);
    assign smp_wrap    = div_wrap && (smp_cnt == frame_max_s);

    // Shadows reload on entry to RUN and at every frame wrap only.
    assign load = ((state == IDLE) && en) || ((state == RUN) && en && smp_wrap);

    // Fibonacci form of x^7 + x^6 + 1: feedback enters at bit 0.
    assign lfsr_nxt = {lfsr[5:0], lfsr[6] ^ lfsr[5]};

    // --------------------------------------------------------- shadows
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            div_max_s   <= '0;
            frame_max_s <= '0;
            sync_len_s  <= '0;
            mode_s      <= '0;
        end else if (load) begin
            div_max_s   <= div_max_eff;
            frame_max_s <= frame_max;
            sync_len_s  <= sync_len;
            mode_s      <= mode;
        end
    end

    // -------------------------------------------------------- counters
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            smp_cnt <= '0;
            lfsr    <= '1;
        end else if ((state == IDLE) || !en) begin
            div_cnt <= '0;
            smp_cnt <= '0;
            lfsr    <= '1;
        end else if (div_wrap) begin
            div_cnt <= '0;
            if (smp_wrap) begin
                smp_cnt <= '0;
                lfsr    <= '1;
            end else begin
                smp_cnt <= smp_cnt + 1'b1;
                lfsr    <= lfsr_nxt;
            end
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // ------------------------------------------------ output functions
    // Extra bit avoids overflow when the shadow limit is all ones.
    assign half_period = ({1'b0, div_max_s} + 1'b1) >> 1;
    assign half_frame  = ({1'b0, frame_max_s} + 1'b1) >> 1;

    assign spclk_d = ({1'b0, div_cnt} < half_period);
    assign sync_d  = (smp_cnt < sync_len_s);

    // Bit k of lfsr_rep is lfsr[k mod 7] for k up to 15.
    assign lfsr_rep = {lfsr[1:0], lfsr, lfsr};

    always_comb begin
        data_d = '0;
        case (mode_s)
            2'b00: if ({1'b0, smp_cnt} < half_frame) data_d = '1;
            // NCHN is a power of two, so masking gives smp_cnt mod NCHN.
            2'b01: data_d = NCHN'(1) << (smp_cnt & CNT_NBIT'(NCHN - 1));
            2'b10: data_d = lfsr_rep[NCHN-1:0];
            default: data_d = '0;
        endcase
    end

    // ------------------------------------------------ output registers
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            spclk      <= 1'b0;
            sync       <= 1'b0;
            data       <= '0;
            frame_tick <= 1'b0;
            sample_idx <= '0;
        end else if (state == IDLE) begin
            spclk      <= 1'b0;
            sync       <= 1'b0;
            data       <= '0;
            frame_tick <= 1'b0;
            sample_idx <= '0;
        end else begin
            spclk      <= spclk_d;
            sync       <= sync_d;
            data       <= data_d;
            frame_tick <= (div_cnt == '0) && (smp_cnt == '0);
            sample_idx <= smp_cnt;
        end
    end

endmodule

// File: tb/tb_sync_gen.sv
// tb_sync_gen: scoreboard bench for sync_gen. Stimulus pushes the expected
// output of every mclk of a scenario into a queue; the monitor pops one entry
// per falling edge while the queue is non-empty and compares all outputs.
module tb_sync_gen;

    logic        mclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [15:0] div_max = '0;
    logic [8:0]  frame_max = '0;
    logic [8:0]  sync_len = '0;
    logic [1:0]  mode = '0;
    logic        spclk;
    logic        sync;
    logic [3:0]  data;
    logic        frame_tick;
    logic [8:0]  sample_idx;

    sync_gen #(.DIV_NBIT(16), .CNT_NBIT(9), .NCHN(4)) dut (
        .mclk       (mclk),
        .rst_n      (rst_n),
        .en         (en),
        .div_max    (div_max),
        .frame_max  (frame_max),
        .sync_len   (sync_len),
        .mode       (mode),
        .spclk      (spclk),
        .sync       (sync),
        .data       (data),
        .frame_tick (frame_tick),
        .sample_idx (sample_idx)
    );

    always #5 mclk = ~mclk;

    typedef struct {
        int         sid;
        int         num;
        logic       sp;
        logic       sy;
        logic [3:0] d;
        logic       tk;
        logic [8:0] idx;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    int   n_run = 0;
    int   n_fail = 0;
    int   sid = 0;
    int   num = 0;

    logic [3:0] wk [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic       seq [133];

    // ------------------------------------------------------------ monitor
    always @(negedge mclk) begin
        if (q.size() > 0) begin
            cur = q.pop_front();
            n_run++;
            if (spclk !== cur.sp || sync !== cur.sy || data !== cur.d ||
                frame_tick !== cur.tk || sample_idx !== cur.idx) begin
                n_fail++;
                $display("FAIL sc%0d[%0d]: got sp=%b sy=%b d=%h tk=%b idx=%0d, expected sp=%b sy=%b d=%h tk=%b idx=%0d",
                         cur.sid, cur.num, spclk, sync, data, frame_tick, sample_idx,
                         cur.sp, cur.sy, cur.d, cur.tk, cur.idx);
            end
        end
    end

    // ---------------------------------------------------------- helpers
    task automatic push_e(input logic sp, input logic sy, input logic [3:0] d,
                          input logic tk, input int idx);
        exp_t e;
        e.sid = sid;
        e.num = num;
        e.sp  = sp;
        e.sy  = sy;
        e.d   = d;
        e.tk  = tk;
        e.idx = 9'(idx);
        num++;
        q.push_back(e);
    endtask

    task automatic push_zeros(input int n);
        for (int i = 0; i < n; i++) push_e(1'b0, 1'b0, 4'h0, 1'b0, 0);
    endtask

    // One sample period: spclk high for the first 'hi' cycles.
    task automatic push_sample(input int period, input int hi, input logic sy,
                               input logic [3:0] d, input logic first, input int idx);
        for (int c = 0; c < period; c++)
            push_e(c < hi, sy, d, first && (c == 0), idx);
    endtask

    // Called one time unit after a rising edge with the DUT idle.
    task automatic start_scn(input int id, input int dm, input int fm,
                             input int sl, input int md);
        sid       = id;
        num       = 0;
        div_max   = 16'(dm);
        frame_max = 9'(fm);
        sync_len  = 9'(sl);
        mode      = 2'(md);
        en        = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 20000; i++) begin
            if (q.size() == 0) break;
            @(posedge mclk);
        end
        if (q.size() != 0) begin
            $display("FAIL drain sc%0d: %0d entries left, required 0", sid, q.size());
            $display("[TB] %0d tests run, %0d failed", n_run, n_fail + 1);
            $fatal(1);
        end
        @(posedge mclk);
        #1;
    endtask

    task automatic stop_run();
        en = 1'b0;
        repeat (3) @(posedge mclk);
        #1;
    endtask

    // ---------------------------------------------------------- stimulus
    initial begin
        logic [3:0] d;

        // a[n] = a[n-7] ^ a[n-6] for taps x^7 + x^6; seq[i] holds a[i-6].
        for (int i = 0; i < 7; i++) seq[i] = 1'b1;
        for (int i = 7; i < 133; i++) seq[i] = seq[i-7] ^ seq[i-6];

        // Reset and idle: all outputs low.
        sid = 0;
        push_zeros(4);
        repeat (2) @(posedge mclk);
        #1 rst_n = 1'b1;
        drain();

        // Square: period 10 (5 high), sync 0..8, data 0..255, 5120-cycle frames.
        start_scn(1, 9, 511, 9, 0);
        push_zeros(2);
        for (int s = 0; s < 512; s++)
            push_sample(10, 5, s < 9, (s < 256) ? 4'hF : 4'h0, s == 0, s);
        push_sample(10, 5, 1'b1, 4'hF, 1'b1, 0);
        drain();
        stop_run();

        // Walking one, period 4, 8-sample frames.
        start_scn(2, 3, 7, 0, 1);
        push_zeros(2);
        for (int s = 0; s < 9; s++)
            push_sample(4, 2, 1'b0, wk[s % 4], (s % 8) == 0, s % 8);
        drain();
        stop_run();

        // PRBS-7, div_max 0 acts as period 2, 127-sample frames, two frames.
        start_scn(3, 0, 126, 3, 2);
        push_zeros(2);
        for (int f = 0; f < 2; f++) begin
            for (int n = 0; n < 127; n++) begin
                for (int k = 0; k < 4; k++) d[k] = seq[n - k + 6];
                push_sample(2, 1, n < 3, d, n == 0, n);
            end
        end
        push_sample(2, 1, 1'b1, 4'hF, 1'b1, 0);
        drain();
        stop_run();

        // Mid-frame frame_max/mode change takes effect at the next frame;
        // sync_len 20 > frame_max 15 keeps sync high for that whole frame.
        start_scn(4, 1, 511, 20, 3);
        push_zeros(2);
        for (int s = 0; s < 512; s++)
            push_sample(2, 1, s < 20, 4'h0, s == 0, s);
        for (int s = 0; s < 16; s++)
            push_sample(2, 1, 1'b1, (s < 8) ? 4'hF : 4'h0, s == 0, s);
        push_sample(2, 1, 1'b1, 4'hF, 1'b1, 0);
        repeat (100) @(posedge mclk);
        #1;
        frame_max = 9'd15;
        mode      = 2'b00;
        drain();
        stop_run();

        // Drop en at sample 100, then restart from sample 0.
        start_scn(5, 1, 511, 9, 0);
        push_zeros(2);
        for (int s = 0; s < 100; s++)
            push_sample(2, 1, s < 9, 4'hF, s == 0, s);
        push_e(1'b1, 1'b0, 4'hF, 1'b0, 100);
        push_zeros(4);
        for (int s = 0; s < 5; s++)
            push_sample(2, 1, s < 9, 4'hF, s == 0, s);
        repeat (201) @(posedge mclk);
        #1 en = 1'b0;
        repeat (4) @(posedge mclk);
        #1 en = 1'b1;
        drain();
        stop_run();

        // Asynchronous reset between edges clears outputs before the next edge.
        start_scn(6, 0, 3, 1, 1);
        push_zeros(2);
        for (int s = 0; s < 6; s++)
            push_sample(2, 1, (s % 4) < 1, wk[s % 4], (s % 4) == 0, s % 4);
        repeat (14) @(posedge mclk);
        #2;
        rst_n = 1'b0;
        en    = 1'b0;
        push_zeros(3);
        drain();
        rst_n = 1'b1;
        repeat (2) @(posedge mclk);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
